adc_lvds_deframer: RTL and testbench



---
 rtl/adc_lvds_deframer.sv | 211 +++++++++++++++++++++
 tb/tb_adc_lvds_deframer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_lvds_deframer.sv
// adc_lvds_deframer: aligns to the LTC2264 FR frame pattern and rebuilds 12-bit
// samples for both channels from IDDR rise/fall bit pairs (2 bit-times per clk).
// Ports: clk/reset (async, active-high); fr_*, ch1_*, ch2_* rise/fall bit pairs in;
// ch1_data/ch2_data, data_valid pulse, locked, frame_err_count, ramp_err_count out.
// Optional ramp checker on ch1 is built only when ADC_DEC_RAMP_CHECK_EN is defined.
// Outputs update one clk after the edge that captured bit-time 7 of a window.
module adc_lvds_deframer #(
    parameter int LOCK_FRAMES = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fr_rise,
    input  logic             fr_fall,
    input  logic [1:0]       ch1_rise,
    input  logic [1:0]       ch1_fall,
    input  logic [1:0]       ch2_rise,
    input  logic [1:0]       ch2_fall,
    output logic [11:0]      ch1_data,
    output logic [11:0]      ch2_data,
    output logic             data_valid,
    output logic             locked,
    output logic [ERR_W-1:0] frame_err_count,
    output logic [ERR_W-1:0] ramp_err_count
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    // Bit-time 0 is the MSB of the window vector, so the pattern reads 1111_0000.
    localparam logic [7:0] FR_PATTERN  = 8'hF0;
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

    state_t     state, state_next;
    logic [2:0] phase, phase_next;
    logic [3:0] good_cnt, good_next;
    logic [3:0] good_inc;

    // slot numbers the pair currently held in hist[1:0]; absolute bit-time of
    // the rise bit is 2*slot, of the fall bit 2*slot+1 (mod 8).
    logic [1:0]      slot;
    logic [8:0]      fr_hist;
    logic [3:0][8:0] lane_hist;   // [0] ch1 lane0, [1] ch1 lane1, [2] ch2 lane0, [3] ch2 lane1

    logic            win_done;
    logic [1:0]      end_slot;
    logic [7:0]      fr_win;
    logic            fr_ok;
    logic [3:0][5:0] lane_win;
    logic [11:0]     ch1_sample, ch2_sample;
    logic            edge_rise, edge_fall, edge_found;
    logic [2:0]      edge_phase;
    logic            take, frame_err_hit;

    // Bit history: newest fall bit at [0], its rise bit at [1].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fr_hist   <= '0;
            lane_hist <= '0;
            slot      <= '0;
        end else begin
            fr_hist      <= {fr_hist[6:0], fr_rise, fr_fall};
            lane_hist[0] <= {lane_hist[0][6:0], ch1_rise[0], ch1_fall[0]};
            lane_hist[1] <= {lane_hist[1][6:0], ch1_rise[1], ch1_fall[1]};
            lane_hist[2] <= {lane_hist[2][6:0], ch2_rise[0], ch2_fall[0]};
            lane_hist[3] <= {lane_hist[3][6:0], ch2_rise[1], ch2_fall[1]};
            slot         <= slot + 2'd1;
        end
    end

    // Bit-time 7 sits at absolute position phase+7; its slot is (phase+7)>>1.
    // With an odd phase bit-time 7 is a rise bit, so the window is shifted up
    // by one in the history (one newer fall bit already belongs to the next window).
    assign end_slot = phase[2:1] + 2'd3 + {1'b0, phase[0]};
    assign win_done = (slot == end_slot);
    assign fr_win   = phase[0] ? fr_hist[8:1] : fr_hist[7:0];
    assign fr_ok    = (fr_win == FR_PATTERN);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_win[k] = phase[0] ? lane_hist[k][8:3] : lane_hist[k][7:2];
        end
    end

    // Lane 0 carries the odd sample bits, lane 1 the even ones, MSB first.
    always_comb begin
        ch1_sample = '0;
        ch2_sample = '0;
        for (int i = 0; i < 6; i++) begin
            ch1_sample[2*i+1] = lane_win[0][i];
            ch1_sample[2*i]   = lane_win[1][i];
            ch2_sample[2*i+1] = lane_win[2][i];
            ch2_sample[2*i]   = lane_win[3][i];
        end
    end

    // 0->1 on FR: either across the pair boundary or inside the newest pair.
    assign edge_rise  = ~fr_hist[2] & fr_hist[1];
    assign edge_fall  = ~fr_hist[1] & fr_hist[0];
    assign edge_found = edge_rise | edge_fall;
    assign edge_phase = edge_rise ? {slot, 1'b0} : {slot, 1'b1};
    assign good_inc   = good_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_HUNT;
            phase    <= '0;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            good_cnt <= good_next;
        end
    end

    // On a bad frame the newest pair may already hold the next FR edge
    // (odd phases), so it is re-latched immediately instead of waiting a window.
    always_comb begin
        state_next    = state;
        phase_next    = phase;
        good_next     = good_cnt;
        take          = 1'b0;
        frame_err_hit = 1'b0;
        case (state)
            ST_HUNT: begin
                if (edge_found) begin
                    state_next = ST_VERIFY;
                    phase_next = edge_phase;
                    good_next  = '0;
                end
            end
            ST_VERIFY: begin
                if (win_done) begin
                    if (fr_ok) begin
                        if (good_inc == LOCK_TARGET) begin
                            state_next = ST_LOCKED;
                            good_next  = '0;
                        end else begin
                            good_next = good_inc;
                        end
                    end else begin
                        good_next  = '0;
                        state_next = edge_found ? ST_VERIFY : ST_HUNT;
                        if (edge_found) phase_next = edge_phase;
                    end
                end
            end
            ST_LOCKED: begin
                if (win_done) begin
                    if (fr_ok) begin
                        take = 1'b1;
                    end else begin
                        frame_err_hit = 1'b1;
                        good_next     = '0;
                        state_next    = edge_found ? ST_VERIFY : ST_HUNT;
                        if (edge_found) phase_next = edge_phase;
                    end
                end
            end
            default: begin
                state_next = ST_HUNT;
            end
        endcase
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_valid      <= 1'b0;
            ch1_data        <= '0;
            ch2_data        <= '0;
            frame_err_count <= '0;
        end else begin
            data_valid <= take;
            if (take) begin
                ch1_data <= ch1_sample;
                ch2_data <= ch2_sample;
            end
            if (frame_err_hit && (frame_err_count != '1)) begin
                frame_err_count <= frame_err_count + 1'b1;
            end
        end
    end

`ifdef ADC_DEC_RAMP_CHECK_EN
    // seeded is cleared whenever not LOCKED so the first sample of each lock
    // period only establishes the reference value.
    logic seeded;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seeded         <= 1'b0;
            ramp_err_count <= '0;
        end else if (state != ST_LOCKED) begin
            seeded <= 1'b0;
        end else if (take) begin
            seeded <= 1'b1;
            if (seeded && (ch1_sample != 12'(ch1_data + 12'd1)) && (ramp_err_count != '1)) begin
                ramp_err_count <= ramp_err_count + 1'b1;
            end
        end
    end
`else
    assign ramp_err_count = '0;
`endif

endmodule

// File: tb/tb_adc_lvds_deframer.sv
module tb_adc_lvds_deframer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fr_rise = 1'b0, fr_fall = 1'b0;
    logic [1:0]  ch1_rise = '0, ch1_fall = '0, ch2_rise = '0, ch2_fall = '0;
    logic [11:0] ch1_data, ch2_data;
    logic        data_valid, locked;
    logic [15:0] frame_err_count, ramp_err_count;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ADC_DEC_RAMP_CHECK_EN
    localparam logic [15:0] RERR1 = 16'd1;
`else
    localparam logic [15:0] RERR1 = 16'd0;
`endif

    adc_lvds_deframer #(.LOCK_FRAMES(4), .ERR_W(16)) dut (
        .clk(clk), .reset(reset),
        .fr_rise(fr_rise), .fr_fall(fr_fall),
        .ch1_rise(ch1_rise), .ch1_fall(ch1_fall),
        .ch2_rise(ch2_rise), .ch2_fall(ch2_fall),
        .ch1_data(ch1_data), .ch2_data(ch2_data),
        .data_valid(data_valid), .locked(locked),
        .frame_err_count(frame_err_count), .ramp_err_count(ramp_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] val;
        logic [7:0]  fr;
        bit          pad;
        bit          out;
        bit          gap4;
        int          exp_lock;   // -1: no check at pair 1 of this window
        logic [15:0] ferr;
        logic [15:0] rerr;
        bit          rst_mid;
    } win_t;

    typedef struct {
        logic [11:0] c1;
        logic [11:0] c2;
        logic [15:0] ferr;
        logic [15:0] rerr;
        bit          gap4;
    } exp_t;

    win_t       tbl[$];
    exp_t       sb[$];
    logic [4:0] bits[$];   // {fr, ch1 l0, ch1 l1, ch2 l0, ch2 l1} per bit-time

    function automatic win_t mk(logic [11:0] v, logic [7:0] fr, bit pad, bit out, bit gap4,
                                int lk, logic [15:0] fe, logic [15:0] re, bit rm);
        win_t w;
        w.val = v; w.fr = fr; w.pad = pad; w.out = out; w.gap4 = gap4;
        w.exp_lock = lk; w.ferr = fe; w.rerr = re; w.rst_mid = rm;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ch1"}, {20'd0, ch1_data}, 32'd0);
        check({tag, "_ch2"}, {20'd0, ch2_data}, 32'd0);
        check({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check({tag, "_ferr"}, {16'd0, frame_err_count}, 32'd0);
        check({tag, "_rerr"}, {16'd0, ramp_err_count}, 32'd0);
    endtask

    task automatic drive_pair(input logic [4:0] r, input logic [4:0] f);
        fr_rise  = r[4];
        fr_fall  = f[4];
        ch1_rise = {r[2], r[3]};
        ch1_fall = {f[2], f[3]};
        ch2_rise = {r[0], r[1]};
        ch2_fall = {f[0], f[1]};
    endtask

    task automatic run_seg(input int lead);
        int   np;
        exp_t e;
        bits.delete();
        repeat (lead) bits.push_back(5'd0);
        foreach (tbl[w]) begin
            logic [11:0] v, nv;
            v  = tbl[w].val;
            nv = ~v;
            for (int t = 0; t < 8; t++) begin
                if (t < 6) bits.push_back({tbl[w].fr[7-t], v[11-2*t], v[10-2*t], nv[11-2*t], nv[10-2*t]});
                else       bits.push_back({tbl[w].fr[7-t], {4{tbl[w].pad}}});
            end
        end
        if (bits.size() % 2 != 0) bits.push_back(5'd0);
        np = bits.size() / 2;
        for (int p = 0; p < np; p++) begin
            @(negedge clk);
            if (lead == 0 && p % 4 == 1 && tbl[p/4].exp_lock >= 0) begin
                check("lock_state", {31'd0, locked}, tbl[p/4].exp_lock);
                check("frame_err", {16'd0, frame_err_count}, {16'd0, tbl[p/4].ferr});
            end
            if (p == 0) reset = 1'b0;
            drive_pair(bits[2*p], bits[2*p+1]);
            if (p % 4 == 0 && p / 4 < tbl.size() && tbl[p/4].out) begin
                e.c1 = tbl[p/4].val; e.c2 = ~tbl[p/4].val;
                e.ferr = tbl[p/4].ferr; e.rerr = tbl[p/4].rerr; e.gap4 = tbl[p/4].gap4;
                sb.push_back(e);
            end
            if (lead == 0 && p % 4 == 2 && tbl[p/4].rst_mid) begin
                #2 reset = 1'b1;
                #1 check_zero("mid_reset");
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a sample.
    initial begin
        int   mcyc = 0;
        int   last_valid = -100;
        exp_t e;
        forever begin
            @(negedge clk);
            mcyc++;
            if (data_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got ch1 %0h with no sample expected", ch1_data);
                end else begin
                    e = sb.pop_front();
                    check("ch1_data", {20'd0, ch1_data}, {20'd0, e.c1});
                    check("ch2_data", {20'd0, ch2_data}, {20'd0, e.c2});
                    check("valid_ferr", {16'd0, frame_err_count}, {16'd0, e.ferr});
                    check("ramp_err", {16'd0, ramp_err_count}, {16'd0, e.rerr});
                    check("valid_locked", {31'd0, locked}, 32'd1);
                    if (e.gap4) check("valid_gap", mcyc - last_valid, 32'd4);
                end
                last_valid = mcyc;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Clean ramp, lock, FR error, relock, skipped ramp value, mid-window reset.
        tbl.delete();
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(12'(i), 8'hF0, 0, 0, 0, (i == 3) ? 0 : -1, 16'd0, 16'd0, 0));
        for (int i = 4; i <= 10; i++)
            tbl.push_back(mk(12'(i), 8'hF0, 0, 1, i > 4, (i == 4) ? 1 : -1, 16'd0, 16'd0, 0));
        tbl.push_back(mk(12'd11, 8'hD0, 0, 0, 0, 1, 16'd0, 16'd0, 0));
        for (int i = 12; i <= 15; i++)
            tbl.push_back(mk(12'(i), 8'hF0, 0, 0, 0, (i == 12 || i == 15) ? 0 : -1, 16'd1, 16'd0, 0));
        tbl.push_back(mk(12'h010, 8'hF0, 0, 1, 0, 1, 16'd1, 16'd0, 0));
        tbl.push_back(mk(12'h012, 8'hF0, 0, 1, 1, -1, 16'd1, RERR1, 0));
        tbl.push_back(mk(12'h013, 8'hF0, 0, 1, 1, -1, 16'd1, RERR1, 0));
        tbl.push_back(mk(12'h014, 8'hF0, 0, 0, 0, 1, 16'd1, RERR1, 1));
        run_seg(0);

        // Relock after reset; wrap 0xFFF->0x000; 0xA5C with padding bits set.
        tbl.delete();
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(12'h015 + 12'(i), 8'hF0, 0, 0, 0, (i == 0 || i == 3) ? 0 : -1, 16'd0, 16'd0, 0));
        tbl.push_back(mk(12'hFFE, 8'hF0, 0, 1, 0, 1, 16'd0, 16'd0, 0));
        tbl.push_back(mk(12'hFFF, 8'hF0, 0, 1, 1, -1, 16'd0, 16'd0, 0));
        tbl.push_back(mk(12'h000, 8'hF0, 0, 1, 1, -1, 16'd0, 16'd0, 0));
        tbl.push_back(mk(12'h001, 8'hF0, 0, 1, 1, -1, 16'd0, 16'd0, 0));
        tbl.push_back(mk(12'hA5C, 8'hF0, 1, 1, 1, -1, 16'd0, RERR1, 0));
        run_seg(0);
        repeat (3) begin
            @(negedge clk);
            drive_pair(5'd0, 5'd0);
        end

        // Same ramp delayed by one bit-time (odd phase).
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        tbl.delete();
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(12'(i), 8'hF0, 0, i >= 4, i > 4, -1, 16'd0, 16'd0, 0));
        run_seg(1);
        repeat (6) begin
            @(negedge clk);
            drive_pair(5'd0, 5'd0);
        end
        check("samples_outstanding", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
